// File: rtl/hynoc_bist_pkg.sv
// Shared definitions for the HyNoC BIST stream generator: LFSR tap constants,
// a width-to-taps helper and the generator FSM state encoding.
package hynoc_bist_pkg;

  localparam logic [15:0] LfsrTaps16 = 16'hB400;
  localparam logic [31:0] LfsrTaps32 = 32'h8020_0003;
  localparam logic [63:0] LfsrTaps64 = 64'hD800_0000_0000_0000;

  // Taps for a Galois right-shift LFSR of the given width; unsupported widths yield zero.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      16:      taps = 64'(LfsrTaps16);
      32:      taps = 64'(LfsrTaps32);
      64:      taps = LfsrTaps64;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLen     = 3'd1,
    StAddr    = 3'd2,
    StPayload = 3'd3,
    StGap     = 3'd4,
    StDone    = 3'd5
  } bist_state_e;

endpackage

// File: rtl/hynoc_bist_lfsr.sv
// Galois LFSR, shift right, taps XORed in when the bit shifted out is 1.
// Only reset reloads the seed.
module hynoc_bist_lfsr #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Next state: one Galois step when advancing, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  // State register with synchronous reseed.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/hynoc_bist_stream_gen.sv
// HyNoC BIST packet stream generator. Emits cfg_nb_packets packets, cycling
// round-robin over NB_ROUTES preloaded headers, each followed by an LFSR payload
// of LFSR-driven length. Define HYNOC_BIST_GAP_EN to insert LFSR-driven idle
// gaps (0..MAX_WAIT cycles) between packets.
module hynoc_bist_stream_gen
  import hynoc_bist_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH       = 32,
  parameter int unsigned FLIT_WIDTH          = PAYLOAD_WIDTH + 1,
  parameter int unsigned LOG2_FIFO_DEPTH     = 5,
  parameter int unsigned NB_ADDRESS_FLITS    = 1,
  parameter int unsigned NB_ROUTES           = 4,
  parameter int unsigned LOG2_MAX_NB_FLITS   = 10,
  parameter int unsigned FLIT_RANDOM_SEED    = 556,
  parameter int unsigned NB_FLIT_RANDOM_SEED = 666,
  parameter int unsigned FIFO_MARGIN         = 2,
  parameter int unsigned MAX_WAIT            = 3
) (
  input  logic                                          local_clk,
  input  logic                                          local_srst_n,
  input  logic                                          start,
  input  logic [15:0]                                   cfg_nb_packets,
  input  logic [NB_ROUTES*NB_ADDRESS_FLITS*FLIT_WIDTH-1:0] route_table,
  output logic                                          local_ingress_write,
  output logic [FLIT_WIDTH-1:0]                         local_ingress_data,
  input  logic [LOG2_FIFO_DEPTH:0]                      local_ingress_fifo_level,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          address_sent,
  output logic                                          packet_sent,
  output logic [15:0]                                   packets_sent
);

  localparam int unsigned NbHdrFlits = NB_ROUTES * NB_ADDRESS_FLITS;
  localparam int unsigned RouteW     = (NB_ROUTES > 1) ? $clog2(NB_ROUTES) : 1;
  localparam int unsigned AddrW      = (NB_ADDRESS_FLITS > 1) ? $clog2(NB_ADDRESS_FLITS) : 1;
  localparam int unsigned SelW       = (NbHdrFlits > 1) ? $clog2(NbHdrFlits) : 1;
  localparam int unsigned LenW       = LOG2_MAX_NB_FLITS + 1;
  localparam int unsigned LevelLimit = (1 << LOG2_FIFO_DEPTH) - FIFO_MARGIN;

  localparam logic [63:0]              DataTapsFull = lfsr_taps(PAYLOAD_WIDTH);
  localparam logic [PAYLOAD_WIDTH-1:0] DataTaps     = DataTapsFull[PAYLOAD_WIDTH-1:0];
  localparam logic [PAYLOAD_WIDTH-1:0] DataSeed     = PAYLOAD_WIDTH'(FLIT_RANDOM_SEED);
  localparam logic [15:0]              LenSeed      = 16'(NB_FLIT_RANDOM_SEED);

  bist_state_e                 state_q;
  logic [15:0]                 nb_packets_q;
  logic [15:0]                 packets_sent_q;
  logic [RouteW-1:0]           route_idx_q;
  logic [AddrW-1:0]            addr_idx_q;
  logic [LenW-1:0]             len_q;
  logic [LenW-1:0]             flit_idx_q;
  logic                        write_q;
  logic [FLIT_WIDTH-1:0]       data_q;
  logic                        busy_q, done_q, address_sent_q, packet_sent_q;
`ifdef HYNOC_BIST_GAP_EN
  logic [1:0]                  gap_q;
  logic [1:0]                  gap_len;
`endif

  logic [PAYLOAD_WIDTH-1:0]    data_value;
  logic [15:0]                 len_value;
  logic [LenW-1:0]             len_next;
  logic                        can_write;
  logic                        is_last;
  logic [SelW-1:0]             hdr_sel;
  logic [FLIT_WIDTH-1:0]       hdr_flits [NbHdrFlits];
  logic [FLIT_WIDTH-1:0]       hdr_flit;
  logic                        unused_len_bits;

  for (genvar i = 0; i < NbHdrFlits; i++) begin : g_hdr
    assign hdr_flits[i] = route_table[i*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Headroom check; FIFO_MARGIN absorbs the latency of the level feedback.
  assign can_write = (32'(local_ingress_fifo_level) < LevelLimit);
  assign is_last   = (flit_idx_q == len_q);
  // Extra MSB lets a length of exactly 2^LOG2_MAX_NB_FLITS be represented.
  assign len_next  = {1'b0, len_value[LOG2_MAX_NB_FLITS-1:0]} + LenW'(1);
  assign unused_len_bits = ^len_value[15:LOG2_MAX_NB_FLITS];
`ifdef HYNOC_BIST_GAP_EN
  assign gap_len   = 2'(32'(len_value[1:0]) % (MAX_WAIT + 1));
`endif

  // Select the current header flit from the route table.
  always_comb begin
    hdr_sel  = SelW'(32'(route_idx_q) * NB_ADDRESS_FLITS + 32'(addr_idx_q));
    hdr_flit = hdr_flits[hdr_sel];
  end

  hynoc_bist_lfsr #(
    .WIDTH (PAYLOAD_WIDTH),
    .TAPS  (DataTaps),
    .SEED  (DataSeed)
  ) u_data_lfsr (
    .clk     (local_clk),
    .srst_n  (local_srst_n),
    .advance (state_q == StPayload && can_write),
    .value   (data_value)
  );

  hynoc_bist_lfsr #(
    .WIDTH (16),
    .TAPS  (LfsrTaps16),
    .SEED  (LenSeed)
  ) u_len_lfsr (
    .clk     (local_clk),
    .srst_n  (local_srst_n),
    .advance (state_q == StLen),
    .value   (len_value)
  );

  // Generator FSM; all outputs are registered here.
  always_ff @(posedge local_clk) begin
    if (!local_srst_n) begin
      state_q        <= StIdle;
      nb_packets_q   <= '0;
      packets_sent_q <= '0;
      route_idx_q    <= '0;
      addr_idx_q     <= '0;
      len_q          <= '0;
      flit_idx_q     <= '0;
      write_q        <= 1'b0;
      data_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      address_sent_q <= 1'b0;
      packet_sent_q  <= 1'b0;
`ifdef HYNOC_BIST_GAP_EN
      gap_q          <= '0;
`endif
    end else begin
      write_q        <= 1'b0;
      address_sent_q <= 1'b0;
      packet_sent_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            nb_packets_q   <= cfg_nb_packets;
            packets_sent_q <= '0;
            route_idx_q    <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= (cfg_nb_packets == 16'd0) ? StDone : StLen;
          end
        end
        StLen: begin
          len_q      <= len_next;
          flit_idx_q <= LenW'(1);
          addr_idx_q <= '0;
          state_q    <= StAddr;
        end
        StAddr: begin
          if (can_write) begin
            write_q <= 1'b1;
            data_q  <= hdr_flit;
            if (addr_idx_q == AddrW'(NB_ADDRESS_FLITS - 1)) begin
              address_sent_q <= 1'b1;
              state_q        <= StPayload;
            end else begin
              addr_idx_q <= addr_idx_q + AddrW'(1);
            end
          end
        end
        StPayload: begin
          if (can_write) begin
            write_q <= 1'b1;
            data_q  <= {is_last, data_value};
            if (is_last) begin
              packet_sent_q  <= 1'b1;
              packets_sent_q <= packets_sent_q + 16'd1;
              route_idx_q    <= (route_idx_q == RouteW'(NB_ROUTES - 1)) ? '0
                                : route_idx_q + RouteW'(1);
              if (packets_sent_q + 16'd1 == nb_packets_q) begin
                state_q <= StDone;
              end else begin
`ifdef HYNOC_BIST_GAP_EN
                gap_q   <= gap_len;
                state_q <= (gap_len == 2'd0) ? StLen : StGap;
`else
                state_q <= StLen;
`endif
              end
            end else begin
              flit_idx_q <= flit_idx_q + LenW'(1);
            end
          end
        end
`ifdef HYNOC_BIST_GAP_EN
        StGap: begin
          if (gap_q == 2'd1) begin
            state_q <= StLen;
          end else begin
            gap_q <= gap_q - 2'd1;
          end
        end
`endif
        StDone: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign local_ingress_write = write_q;
  assign local_ingress_data  = data_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign address_sent        = address_sent_q;
  assign packet_sent         = packet_sent_q;
  assign packets_sent        = packets_sent_q;

endmodule

// File: tb/tb_hynoc_bist_stream_gen.sv
// Directed self-checking bench for hynoc_bist_stream_gen (default parameters).
module tb_hynoc_bist_stream_gen;

  localparam int PW = 32;
  localparam int FW = 33;
  localparam int NR = 4;
  localparam int NA = 1;

  logic                  local_clk = 1'b0;
  logic                  local_srst_n = 1'b0;
  logic                  start = 1'b0;
  logic [15:0]           cfg_nb_packets = '0;
  logic [NR*NA*FW-1:0]   route_table;
  logic                  local_ingress_write;
  logic [FW-1:0]         local_ingress_data;
  logic [5:0]            local_ingress_fifo_level = '0;
  logic                  busy, done, address_sent, packet_sent;
  logic [15:0]           packets_sent;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  logic [FW-1:0] got_data[$];
  int unsigned   got_cyc[$];
  int            n_addr = 0;
  int            n_pkt = 0;

  logic [FW-1:0] exp_q[$];
  int            exp_hdr[$];
  int            exp_gap[$];
  logic [31:0]   m_data;
  logic [15:0]   m_len;

  hynoc_bist_stream_gen dut (
    .local_clk                (local_clk),
    .local_srst_n             (local_srst_n),
    .start                    (start),
    .cfg_nb_packets           (cfg_nb_packets),
    .route_table              (route_table),
    .local_ingress_write      (local_ingress_write),
    .local_ingress_data       (local_ingress_data),
    .local_ingress_fifo_level (local_ingress_fifo_level),
    .busy                     (busy),
    .done                     (done),
    .address_sent             (address_sent),
    .packet_sent              (packet_sent),
    .packets_sent             (packets_sent)
  );

  always #5 local_clk = ~local_clk;

  always @(posedge local_clk) cyc <= cyc + 1;

  // Capture every written flit with its cycle stamp, and count the pulses.
  always @(negedge local_clk) begin
    if (local_ingress_write === 1'b1) begin
      got_data.push_back(local_ingress_data);
      got_cyc.push_back(cyc);
    end
    if (address_sent === 1'b1) n_addr = n_addr + 1;
    if (packet_sent === 1'b1) n_pkt = n_pkt + 1;
  end

  function automatic void model_reset();
    m_data = 32'd556;
    m_len  = 16'd666;
  endfunction

  // Append one expected packet (header + payload) and the expected header-to-header gap.
  function automatic void model_packet(input int r);
    int len;
    exp_hdr.push_back(exp_q.size());
    exp_q.push_back(route_table[r*FW +: FW]);
    len   = int'(m_len[9:0]) + 1;
    m_len = (m_len >> 1) ^ (m_len[0] ? 16'hB400 : 16'h0000);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), m_data});
      m_data = (m_data >> 1) ^ (m_data[0] ? 32'h8020_0003 : 32'h0);
    end
`ifdef HYNOC_BIST_GAP_EN
    exp_gap.push_back(2 + int'(m_len[1:0]) % 4);
`else
    exp_gap.push_back(2);
`endif
  endfunction

  task automatic run_start(input logic [15:0] n, output int unsigned c);
    @(negedge local_clk);
    got_data.delete();
    got_cyc.delete();
    exp_q.delete();
    exp_hdr.delete();
    exp_gap.delete();
    n_addr = 0;
    n_pkt = 0;
    cfg_nb_packets = n;
    start = 1'b1;
    @(negedge local_clk);
    c = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge local_clk);
    end
  endtask

  task automatic test_reset();
    local_srst_n = 1'b0;
    start = 1'b0;
    local_ingress_fifo_level = '0;
    repeat (3) @(negedge local_clk);
    total++; if (local_ingress_write !== 1'b0) begin bad++; $display("FAIL rst_write got=%b want=0", local_ingress_write); end
    total++; if (local_ingress_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", local_ingress_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (address_sent !== 1'b0) begin bad++; $display("FAIL rst_address_sent got=%b want=0", address_sent); end
    total++; if (packet_sent !== 1'b0) begin bad++; $display("FAIL rst_packet_sent got=%b want=0", packet_sent); end
    total++; if (packets_sent !== 16'd0) begin bad++; $display("FAIL rst_packets_sent got=%0d want=0", packets_sent); end
    local_srst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    int unsigned c;
    bit ok;
    int n;
    run_start(16'd1, c);
    model_packet(0);
    wait_done(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 want=1"); end
    total++;
    if (got_cyc.size() == 0 || got_cyc[0] != c + 2) begin
      bad++; $display("FAIL single_first_write_cycle got=%0d want=%0d",
                      (got_cyc.size() == 0) ? -1 : int'(got_cyc[0] - c), 2);
    end
    total++; if (got_data.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        bad++; $display("FAIL single_flit[%0d] got=%h want=%h", i,
                        (i < got_data.size()) ? got_data[i] : 'x, exp_q[i]);
      end
    end
    total++; if (got_data.size() < 2 || got_data[1] !== {1'b0, 32'd556}) begin bad++; $display("FAIL single_seed_flit got=%h want=%h", (got_data.size() < 2) ? 'x : got_data[1], {1'b0, 32'd556}); end
    n = got_data.size();
    total++; if (n == 0 || got_data[n-1][FW-1] !== 1'b1) begin bad++; $display("FAIL single_last_msb got=%b want=1", (n == 0) ? 1'bx : got_data[n-1][FW-1]); end
    total++; if (n_pkt != 1) begin bad++; $display("FAIL single_packet_sent_pulses got=%0d want=1", n_pkt); end
    total++; if (n_addr != 1) begin bad++; $display("FAIL single_address_sent_pulses got=%0d want=1", n_addr); end
    total++; if (packets_sent !== 16'd1) begin bad++; $display("FAIL single_packets_sent got=%0d want=1", packets_sent); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
  endtask

  task automatic test_zero();
    int unsigned c;
    bit ok;
    run_start(16'd0, c);
    wait_done(2, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
    repeat (3) @(negedge local_clk);
    total++; if (got_data.size() != 0) begin bad++; $display("FAIL zero_writes got=%0d want=0", got_data.size()); end
    total++; if (packets_sent !== 16'd0) begin bad++; $display("FAIL zero_packets_sent got=%0d want=0", packets_sent); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", busy); end
  endtask

  task automatic test_routes();
    int unsigned c;
    bit ok;
    int hi;
    int bubbles;
    int d;
    run_start(16'd8, c);
    for (int k = 0; k < 8; k++) model_packet(k % NR);
    wait_done(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL routes_done_timeout got=0 want=1"); end
    total++; if (got_data.size() != exp_q.size()) begin bad++; $display("FAIL routes_count got=%0d want=%0d", got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        bad++; $display("FAIL routes_flit[%0d] got=%h want=%h", i,
                        (i < got_data.size()) ? got_data[i] : 'x, exp_q[i]);
      end
    end
    if (got_cyc.size() == exp_q.size()) begin
      hi = 1;
      bubbles = 0;
      for (int i = 1; i < got_cyc.size(); i++) begin
        d = int'(got_cyc[i] - got_cyc[i-1]);
        if (hi < exp_hdr.size() && i == exp_hdr[hi]) begin
          total++;
          if (d != exp_gap[hi-1]) begin
            bad++; $display("FAIL routes_gap[%0d] got=%0d want=%0d", hi, d, exp_gap[hi-1]);
          end
          hi++;
        end else if (d != 1) begin
          bubbles++;
        end
      end
      total++; if (bubbles != 0) begin bad++; $display("FAIL routes_bubbles got=%0d want=0", bubbles); end
    end
    total++; if (packets_sent !== 16'd8) begin bad++; $display("FAIL routes_packets_sent got=%0d want=8", packets_sent); end
    total++; if (n_pkt != 8) begin bad++; $display("FAIL routes_packet_sent_pulses got=%0d want=8", n_pkt); end
    total++; if (n_addr != 8) begin bad++; $display("FAIL routes_address_sent_pulses got=%0d want=8", n_addr); end
  endtask

  task automatic test_flow();
    int unsigned c;
    bit ok;
    int stalled_writes;
    test_reset();
    run_start(16'd1, c);
    model_packet(0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_data.size() >= 6) begin ok = 1'b1; break; end
      @(negedge local_clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL flow_start_timeout got=%0d want=6", got_data.size()); end
    local_ingress_fifo_level = 6'd30;
    stalled_writes = 0;
    repeat (20) begin
      @(negedge local_clk);
      if (local_ingress_write !== 1'b0) stalled_writes++;
    end
    total++; if (stalled_writes != 0) begin bad++; $display("FAIL flow_stall_writes got=%0d want=0", stalled_writes); end
    local_ingress_fifo_level = 6'd29;
    wait_done(2000, ok);
    local_ingress_fifo_level = 6'd0;
    total++; if (!ok) begin bad++; $display("FAIL flow_done_timeout got=0 want=1"); end
    total++; if (got_data.size() != exp_q.size()) begin bad++; $display("FAIL flow_count got=%0d want=%0d", got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        bad++; $display("FAIL flow_flit[%0d] got=%h want=%h", i,
                        (i < got_data.size()) ? got_data[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned c;
    bit ok;
    run_start(16'd1, c);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_data.size() >= 10) begin ok = 1'b1; break; end
      @(negedge local_clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL midrst_start_timeout got=%0d want=10", got_data.size()); end
    local_srst_n = 1'b0;
    @(negedge local_clk);
    total++; if (local_ingress_write !== 1'b0) begin bad++; $display("FAIL midrst_write got=%b want=0", local_ingress_write); end
    total++; if (local_ingress_data !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", local_ingress_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (packets_sent !== 16'd0) begin bad++; $display("FAIL midrst_packets_sent got=%0d want=0", packets_sent); end
    total++; if (packet_sent !== 1'b0 || address_sent !== 1'b0) begin bad++; $display("FAIL midrst_pulses got=%b%b want=00", address_sent, packet_sent); end
    @(negedge local_clk);
    local_srst_n = 1'b1;
    model_reset();
    run_start(16'd1, c);
    model_packet(0);
    wait_done(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_done_timeout got=0 want=1"); end
    total++; if (got_data.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        bad++; $display("FAIL midrst_flit[%0d] got=%h want=%h", i,
                        (i < got_data.size()) ? got_data[i] : 'x, exp_q[i]);
      end
    end
  endtask

  initial begin
    route_table = {{1'b1, 32'h3333_0AB5}, {1'b0, 32'h2222_0AB4},
                   {1'b1, 32'h1111_0AB3}, {1'b0, 32'h0000_0AB2}};
    test_reset();
    test_single();
    test_zero();
    test_routes();
    test_flow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hynoc_bist_stream_gen.md
# hynoc_bist_stream_gen

Synthesizable, parametrised packet stream generator for HyNoC built-in self-test. It drives the ingress side of a `hynoc_local_interface` in the local clock domain. It emits `cfg_nb_packets` packets and cycles round-robin over `NB_ROUTES` preloaded address headers. Each packet carries an LFSR-generated payload whose length is also LFSR-driven, so an on-chip checker or a bench model can regenerate it. Ingress flow control uses the FIFO level.

## Interface
Parameters:
- `PAYLOAD_WIDTH`, 32: payload bits per flit; must be 16, 32 or 64.
- `FLIT_WIDTH`, `PAYLOAD_WIDTH+1`: flit width; the MSB is the last-flit flag.
- `LOG2_FIFO_DEPTH`, 5: depth of the downstream ingress FIFO.
- `NB_ADDRESS_FLITS`, 1: address flits per packet header.
- `NB_ROUTES`, 4: number of route headers cycled round-robin; must be ≥1.
- `LOG2_MAX_NB_FLITS`, 10: payload length range is 1..2^`LOG2_MAX_NB_FLITS`.
- `FLIT_RANDOM_SEED`, 556: data LFSR seed; must be nonzero.
- `NB_FLIT_RANDOM_SEED`, 666: length LFSR seed; must be nonzero.
- `FIFO_MARGIN`, 2: free slots kept in reserve to cover fifo_level latency.
- `MAX_WAIT`, 3: maximum inter-packet gap in cycles (gap feature only).

Ports:
- `local_clk`  in  1  clock. One clock; reset is synchronous and active-low.
- `local_srst_n`  in  1  synchronous active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `cfg_nb_packets`  in  16  packets per run; sampled on accepted `start`.
- `route_table`  in  `NB_ROUTES*NB_ADDRESS_FLITS*FLIT_WIDTH`  headers; route r occupies slice r, and flit 0 of each route sits in the LSBs.
- `local_ingress_write`  out  1  flit write strobe.
- `local_ingress_data`  out  `FLIT_WIDTH`  flit.
- `local_ingress_fifo_level`  in  `LOG2_FIFO_DEPTH+1`  downstream FIFO occupancy.
- `busy`  out  1  run in progress.
- `done`  out  1  sticky; run complete.
- `address_sent`  out  1  pulse on the write of the last address flit.
- `packet_sent`  out  1  pulse on the write of the last payload flit.
- `packets_sent`  out  16  packets completed in the current run.

## Operation
- FSM states: IDLE, LEN, ADDR, PAYLOAD, GAP, DONE.
- IDLE:
  - On `start`: latch `cfg_nb_packets`, clear `done`, `packets_sent` and route index, set `busy`.
  - If the latched count is 0, go to DONE; otherwise go to LEN.
  - `start` in any other state is ignored.
- LEN (1 cycle):
  - Latch payload length = `len_lfsr[LOG2_MAX_NB_FLITS-1:0]` + 1, using (`LOG2_MAX_NB_FLITS`+1)-bit arithmetic so length 2^N is representable.
  - Advance the length LFSR. Go to ADDR.
- ADDR:
  - Emit flits 0..`NB_ADDRESS_FLITS`-1 of the current route verbatim from `route_table`; the MSB is whatever the table holds.
  - After the last address flit: pulse `address_sent`, go to PAYLOAD.
- PAYLOAD:
  - Emit flit {last, data_lfsr}; advance the data LFSR on each write.
  - `last`=1 only on the final flit.
  - On the final flit:
    - pulse `packet_sent`, increment `packets_sent`, advance the route index (wrap `NB_ROUTES`-1 → 0);
    - if `packets_sent`+1 equals the latched count, go to DONE; otherwise go to GAP, or straight to LEN when the gap feature is compiled out.
- DONE: `busy`=0, `done`=1. Return to IDLE in the same cycle; `done` stays high until the next accepted `start`.
- Flow control:
  - A write occurs only when the FSM is in ADDR/PAYLOAD and `local_ingress_fifo_level` < 2^`LOG2_FIFO_DEPTH` − `FIFO_MARGIN`.
  - Otherwise the FSM stalls with data, counters and LFSRs held.
- LFSRs are Galois, shift right, and XOR the taps when the LSB is 1. They are not reseeded between runs; only reset reseeds them.

## Timing
- Outputs are registered. `local_ingress_write` is high for exactly one cycle per flit, with at most one flit per cycle.
- First address flit: earliest 2 cycles after `start` is sampled (IDLE→LEN→ADDR write).
- Back-to-back flits: no bubbles within a packet while the level condition holds.
- Inter-packet overhead: 1 cycle (LEN), plus the gap if enabled.
- Reset values: write=0, data=0, busy=0, done=0, address_sent=0, packet_sent=0, packets_sent=0, state IDLE, LFSRs at seed, route index 0.
- Reset asserted mid-packet: write deasserts on the next edge with no partial completion. The downstream truncated packet is the system's responsibility.

## Configuration
- `HYNOC_BIST_GAP_EN` defined:
  - After each non-final packet, GAP idles for g = `len_lfsr[1:0]` mod (`MAX_WAIT`+1) cycles, sampled on entry (g=0 goes directly to LEN).
  - `len_lfsr` does not advance during GAP.
- `HYNOC_BIST_GAP_EN` undefined: GAP state is absent; PAYLOAD → LEN directly.

## Structure
- Package `hynoc_bist_pkg` holds:
  - LFSR tap constants: 16'hB400 (length, and 16-bit data), 32'h8020_0003, 64'hD800_0000_0000_0000;
  - function `lfsr_taps(width)`;
  - the FSM state enum.
- Sub-module `hynoc_bist_lfsr` (WIDTH, TAPS, SEED; ports clk, srst_n, advance, value) is instantiated twice: data and length.

## Test plan
- Reset, then `start` with `cfg_nb_packets`=1, 1 route {1'b0, 32'h0000_0AB2}, level=0 → address flit at start+2; first payload flit = seed-derived value 556; final flit MSB=1; `packet_sent` and `done` assert; `packets_sent`=1.
- `cfg_nb_packets`=0 → `done`=1 within 2 cycles; no write.
- 8 packets, `NB_ROUTES`=4 → header order r0,r1,r2,r3,r0,r1,r2,r3; `packets_sent`=8; a bench LFSR model matches every payload and length.
- Hold level=30 (depth 32, margin 2) for 20 cycles mid-payload → no writes; resumes with the unchanged next flit once level=29.
- Deassert `local_srst_n` mid-payload → write=0 next edge; all outputs at reset values; a new run reproduces the first packet identically.
- With `HYNOC_BIST_GAP_EN` and `MAX_WAIT`=3 → measured gaps ∈ {0..3} and match the model; without the macro, inter-packet gap is exactly 1 cycle.
